add64_seq_ctrl: RTL and testbench



---
 rtl/add64_seq_ctrl_if.sv | 25 ++
 rtl/add64_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_add64_seq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/add64_seq_ctrl_if.sv
// Request/response bundle between a requester and the 64-bit add/subtract
// sequencer. The requester raises start with operands, the sequencer reports
// busy/done and the result with its flags.
interface add64_seq_ctrl_if;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/add64_seq_ctrl.sv
// 64-bit add/subtract sequencer built around a single 32-bit ripple-carry
// adder. The low half is added first, its carry-out is registered, and the
// high half is added on the following cycle. Carry, signed-overflow and
// zero flags are produced alongside the result.

// Plain 32-bit ripple-carry adder; the only adder in the design.
module rca_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    // Bit-serial carry ripple from bit 0 to bit 31
    always_comb begin
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < 32; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end
endmodule

module add64_seq_ctrl (
    input  logic              clk,
    input  logic              rst,
    add64_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_sub;
    logic        r_c_mid;
    logic [63:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;

    logic [63:0] w_b_eff;
    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_cin;
    logic [31:0] w_add_sum;
    logic        w_add_cout;

    // Subtraction is a + ~b + 1; the +1 enters as the low-half carry-in.
    assign w_b_eff = r_b ^ {64{r_sub}};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start is honoured only in IDLE, nothing is queued
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LO;
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Adder operand select: low half by default, high half with the
    // registered inter-half carry while in HI
    always_comb begin
        w_add_a   = r_a[31:0];
        w_add_b   = w_b_eff[31:0];
        w_add_cin = r_sub;
        if (r_state == S_HI) begin
            w_add_a   = r_a[63:32];
            w_add_b   = w_b_eff[63:32];
            w_add_cin = r_c_mid;
        end
    end

    rca_32bit u_rca (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Operand capture on accept, low-half result in LO, high half and flags in HI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_c_mid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_sub <= bus.sub;
                    end
                end
                S_LO: begin
                    r_sum[31:0] <= w_add_sum;
                    r_c_mid     <= w_add_cout;
                end
                S_HI: begin
                    r_sum[63:32] <= w_add_sum;
                    r_cout       <= w_add_cout;
                    // Operands of equal sign producing a result of the other sign
                    r_ovf        <= (r_a[63] == w_b_eff[63]) && (w_add_sum[31] != r_a[63]);
                    r_zero       <= (w_add_sum == 32'd0) && (r_sum[31:0] == 32'd0);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Directed and randomized bench for add64_seq_ctrl against an arithmetic
// reference model.
module tb_add64_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    add64_seq_ctrl_if bus ();

    add64_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact unsigned and signed arithmetic, then reduced mod 2^64
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         output logic [63:0] s, output logic c, output logic o, output logic z);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] t;
        logic [65:0]        tu;
        ea = {{2{a[63]}}, a};
        eb = {{2{b[63]}}, b};
        t  = sub ? (ea - eb) : (ea + eb);
        tu = t;
        s  = tu[63:0];
        if (sub) c = (a >= b);
        else     c = (({1'b0, a} + {1'b0, b}) >= 65'h1_0000_0000_0000_0000);
        o  = !((tu[65:63] == 3'b000) || (tu[65:63] == 3'b111));
        z  = (s == 64'd0);
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub, input string tag);
        logic [63:0] es;
        logic        ec, eo, ez;
        int          lat;
        model(a, b, sub, es, ec, eo, ez);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, bus.cout, ec);
        chk({tag, "_ovf"}, bus.ovf, eo);
        chk({tag, "_zero"}, bus.zero, ez);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int          pulses;
        int          first_at;
        int          last_at;
        logic [63:0] es;
        logic        ec, eo, ez;
        logic        saw_done;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_flags", {bus.cout, bus.ovf, bus.zero}, 0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, "cross_half");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "full_wrap");
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, "sub_ovf");
        do_op(64'd5, 64'd7, 1'b1, "borrow");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ovf");
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, "sub_zero");

        // Asynchronous reset in the middle of HI aborts the operation
        bus.a     = 64'h1234_5678_9ABC_DEF0;
        bus.b     = 64'd1;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_flags", {bus.cout, bus.ovf, bus.zero}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        do_op(64'd2, 64'd3, 1'b0, "after_rst");

        // Start pulses with other operands during LO, HI and DONE are ignored
        model(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, es, ec, eo, ez);
        bus.a     = 64'hDEAD_BEEF_0000_0001;
        bus.b     = 64'h0000_0001_FFFF_FFFF;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a     = 64'h1111_1111_1111_1111;
        bus.b     = 64'h2222_2222_2222_2222;
        bus.sub   = 1'b0;
        @(posedge clk); #1;
        bus.a     = 64'h3333_3333_3333_3333;
        @(posedge clk); #1;
        chk("ign_done", bus.done, 1);
        chk("ign_sum", bus.sum, es);
        chk("ign_flags", {bus.cout, bus.ovf, bus.zero}, {ec, eo, ez});
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign_idle", bus.busy, 0);
        @(posedge clk); #1;
        chk("ign_no_requeue", bus.busy, 0);

        // Start held high for 12 cycles
        pulses    = 0;
        first_at  = -1;
        last_at   = -1;
        bus.a     = 64'd100;
        bus.b     = 64'd23;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (last_at >= 0) chk("b2b_spacing", i - last_at, 4);
                if (first_at < 0) first_at = i;
                last_at = i;
                pulses++;
                chk("b2b_sum", bus.sum, 64'd123);
            end
        end
        bus.start = 1'b0;
        chk("b2b_pulses", pulses, 3);
        chk("b2b_first", first_at, 3);
        @(posedge clk); #1;
        chk("b2b_idle", bus.busy, 0);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            logic [63:0] ra, rb;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (n % 6 == 1) rb = ra;
            if (n % 6 == 2) rb = ~ra;
            do_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
